// File: rtl/controle_venda.sv
// controle_venda: vending machine transaction controller.
// Accumulates coin credit, decides when a completed keypad selection may be
// dispensed, returns change one unit at a time and releases (OK) or aborts
// (tempoLimite) the keypad digit controller.
//
// Ports
//   i_clk, i_reset      clock, asynchronous active-high reset
//   i_moeda[1:0]        one-cycle coin code: 00 none, 01=1u, 10=2u, 11=4u
//   i_teclaAtiva        keypad activity, restarts the inactivity timeout
//   i_cancelar          one-cycle cancel request
//   i_selecaoPronta     level, a row/column selection is complete
//   i_preco[5:0]        price in units of the current selection
//   i_estoqueVazio      selected slot is empty
//   o_OK                pulse, releases the digit controller
//   o_tempoLimite       pulse, inactivity timeout
//   o_liberarProduto    pulse, dispense command
//   o_trocoPulso        pulse, returns one unit of change
//   o_moedaRejeitada    pulse, coin routed to the return chute
//   o_erroEstoque       level, out-of-stock indication
//   o_credito[5:0]      current credit in units
//   o_estado[2:0]       current state code (debug)
module controle_venda #(
    parameter int unsigned TIMEOUT_CICLOS  = 500,
    parameter int unsigned TROCO_INTERVALO = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [1:0] i_moeda,
    input  logic       i_teclaAtiva,
    input  logic       i_cancelar,
    input  logic       i_selecaoPronta,
    input  logic [5:0] i_preco,
    input  logic       i_estoqueVazio,
    output logic       o_OK,
    output logic       o_tempoLimite,
    output logic       o_liberarProduto,
    output logic       o_trocoPulso,
    output logic       o_moedaRejeitada,
    output logic       o_erroEstoque,
    output logic [5:0] o_credito,
    output logic [2:0] o_estado
);

    localparam int unsigned CW  = 6;
    localparam int unsigned TOW = $clog2(TIMEOUT_CICLOS);
    localparam int unsigned TRW = (TROCO_INTERVALO > 1) ? $clog2(TROCO_INTERVALO) : 1;
    localparam logic [TOW-1:0] TO_FIM     = TOW'(TIMEOUT_CICLOS - 1);
    localparam logic [TRW-1:0] TR_RECARGA = TRW'(TROCO_INTERVALO - 1);
    localparam logic [CW:0]    CRED_MAX   = 7'd63;

    typedef enum logic [2:0] {
        OCIOSO     = 3'd0,
        CREDITANDO = 3'd1,
        LIBERA     = 3'd2,
        DEVOLVE    = 3'd3,
        CONCLUI    = 3'd4
    } estado_t;

    estado_t        r_estado,    w_estado;
    logic [CW-1:0]  r_credito,   w_credito;
    logic [CW-1:0]  r_preco,     w_preco;
    logic [TOW-1:0] r_cnt_tempo, w_cnt_tempo;
    logic [TRW-1:0] r_cnt_troco, w_cnt_troco;
    logic           r_ok,      w_ok;
    logic           r_tempo,   w_tempo;
    logic           r_liberar, w_liberar;
    logic           r_troco,   w_troco;
    logic           r_rejeita, w_rejeita;
    logic           r_erro,    w_erro;

    logic [CW:0]    w_valor;
    logic [CW:0]    w_soma;
    logic           w_aceita;
    logic [CW-1:0]  w_resto;
    logic           w_tem_credito;

    // Coin value decode and saturation test (sum above 63 is rejected).
    always_comb begin
        w_valor = '0;
        case (i_moeda)
            2'b01:   w_valor = 7'd1;
            2'b10:   w_valor = 7'd2;
            2'b11:   w_valor = 7'd4;
            default: w_valor = '0;
        endcase
    end

    assign w_soma        = {1'b0, r_credito} + w_valor;
    assign w_aceita      = (i_moeda != 2'b00) && (w_soma <= CRED_MAX);
    assign w_resto       = r_credito - r_preco;
    assign w_tem_credito = (r_credito != '0);

    // State register and all registered outputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_estado    <= OCIOSO;
            r_credito   <= '0;
            r_preco     <= '0;
            r_cnt_tempo <= '0;
            r_cnt_troco <= '0;
            r_ok        <= 1'b0;
            r_tempo     <= 1'b0;
            r_liberar   <= 1'b0;
            r_troco     <= 1'b0;
            r_rejeita   <= 1'b0;
            r_erro      <= 1'b0;
        end else begin
            r_estado    <= w_estado;
            r_credito   <= w_credito;
            r_preco     <= w_preco;
            r_cnt_tempo <= w_cnt_tempo;
            r_cnt_troco <= w_cnt_troco;
            r_ok        <= w_ok;
            r_tempo     <= w_tempo;
            r_liberar   <= w_liberar;
            r_troco     <= w_troco;
            r_rejeita   <= w_rejeita;
            r_erro      <= w_erro;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_estado    = r_estado;
        w_credito   = r_credito;
        w_preco     = r_preco;
        w_cnt_tempo = '0;
        w_cnt_troco = '0;
        w_ok        = 1'b0;
        w_tempo     = 1'b0;
        w_liberar   = 1'b0;
        w_troco     = 1'b0;
        w_rejeita   = 1'b0;
        w_erro      = r_erro;

        case (r_estado)
            OCIOSO, CREDITANDO: begin
                // Coin is credited even when a transition happens on this edge.
                if (w_aceita) begin
                    w_credito = w_soma[CW-1:0];
                    if (r_estado == OCIOSO) begin
                        w_estado = CREDITANDO;
                    end
                end else if (i_moeda != 2'b00) begin
                    w_rejeita = 1'b1;
                end

                // Decisions use the pre-edge credit; leaving clears the timer.
                if (i_cancelar) begin
                    w_estado = w_tem_credito ? DEVOLVE : CONCLUI;
                end else if (i_selecaoPronta && i_estoqueVazio) begin
                    w_erro   = 1'b1;
                    w_estado = w_tem_credito ? DEVOLVE : CONCLUI;
                end else if (i_selecaoPronta && (r_credito >= i_preco)) begin
                    w_preco  = i_preco;
                    w_estado = LIBERA;
                end else if (w_aceita || i_teclaAtiva) begin
                    w_cnt_tempo = '0;
                end else if (r_cnt_tempo == TO_FIM) begin
                    w_tempo = 1'b1;
                    if (w_tem_credito) begin
                        w_estado = DEVOLVE;
                    end else if (i_selecaoPronta) begin
                        w_estado = CONCLUI;
                    end
                end else begin
                    w_cnt_tempo = r_cnt_tempo + TOW'(1);
                end
            end

            LIBERA: begin
                w_liberar = 1'b1;
                w_rejeita = (i_moeda != 2'b00);
                w_credito = w_resto;
                w_estado  = (w_resto != '0) ? DEVOLVE : CONCLUI;
            end

            DEVOLVE: begin
                // Interval counter enters at zero so the first unit goes out at once.
                w_rejeita = (i_moeda != 2'b00);
                if (!w_tem_credito) begin
                    w_estado = CONCLUI;
                end else if (r_cnt_troco == '0) begin
                    w_troco     = 1'b1;
                    w_credito   = r_credito - CW'(1);
                    w_cnt_troco = TR_RECARGA;
                    if (r_credito == CW'(1)) begin
                        w_estado = CONCLUI;
                    end
                end else begin
                    w_cnt_troco = r_cnt_troco - TRW'(1);
                end
            end

            CONCLUI: begin
                w_ok      = 1'b1;
                w_rejeita = (i_moeda != 2'b00);
                w_erro    = 1'b0;
                w_estado  = OCIOSO;
            end

            default: begin
                // Unused codes recover to idle.
                w_erro   = 1'b0;
                w_estado = OCIOSO;
            end
        endcase
    end

    assign o_OK             = r_ok;
    assign o_tempoLimite    = r_tempo;
    assign o_liberarProduto = r_liberar;
    assign o_trocoPulso     = r_troco;
    assign o_moedaRejeitada = r_rejeita;
    assign o_erroEstoque    = r_erro;
    assign o_credito        = r_credito;
    assign o_estado         = r_estado;

endmodule
